rat_recovery_ctrl: RTL and testbench

Sequences RAT recovery after a branch mispredict or exception squash. The RAT is rebuilt from the RRAT over several cycles, COPY_WIDTH architectural entries per cycle, and the free list is restored from the retirement copy once the walk finishes. The block sits between the retire stage (squash source, RRAT read port) and the rename stage (RAT write port, free-list restore, dispatch stall). It also freezes retirement while the walk is in progress, so the RRAT stays stable.

---
 rtl/rat_recovery_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rat_recovery_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rat_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rat_recovery_ctrl
// Purpose  : Sequences RAT recovery after a branch mispredict or exception
//            squash. It rebuilds the RAT from the RRAT, COPY_WIDTH entries per
//            cycle, then restores the free list from its retirement copy.
//            Dispatch is stalled and retirement is held for the whole walk.
//
// Ports    : clock_i              sole clock
//            reset_i              synchronous, active-low reset
//            squash_req_i         one-cycle squash pulse from retire
//            rrat_rd_idx_o        RRAT group index (combinational read)
//            rrat_rd_data_i       RRAT group contents, entry i at
//                                 [i*PRN_WIDTH +: PRN_WIDTH]
//            rat_wr_en_o          RAT group write enable
//            rat_wr_idx_o         RAT group written
//            rat_wr_data_o        RRAT group data passed through to the RAT
//            fl_restore_en_o      free list copies the RRAT free list
//            dispatch_stall_o     rename/dispatch must not allocate
//            ct_hold_o            retire must not update the RRAT
//            recovery_busy_o      controller is not idle
//            recovery_done_o      one-cycle pulse when recovery completes
//            perf_squash_cnt_o    (RAT_RECOVERY_PERF_EN) accepted squashes
//            perf_stall_cycles_o  (RAT_RECOVERY_PERF_EN) stalled cycles
//
// Options  : define RAT_RECOVERY_PERF_EN to add the saturating perf counters.
//
// Revision : 1.0 - initial release
// ============================================================================
module rat_recovery_ctrl #(
  parameter int ARCH_REGS  = 32,
  parameter int PRN_WIDTH  = 6,
  parameter int COPY_WIDTH = 4,
  localparam int NUM_GROUPS = ARCH_REGS / COPY_WIDTH,
  localparam int IDX_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int DATA_W     = COPY_WIDTH * PRN_WIDTH
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              squash_req_i,
  output logic [IDX_W-1:0]  rrat_rd_idx_o,
  input  logic [DATA_W-1:0] rrat_rd_data_i,
  output logic              rat_wr_en_o,
  output logic [IDX_W-1:0]  rat_wr_idx_o,
  output logic [DATA_W-1:0] rat_wr_data_o,
  output logic              fl_restore_en_o,
  output logic              dispatch_stall_o,
  output logic              ct_hold_o,
  output logic              recovery_busy_o,
  output logic              recovery_done_o
`ifdef RAT_RECOVERY_PERF_EN
  ,
  output logic [31:0]       perf_squash_cnt_o,
  output logic [31:0]       perf_stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COPY    = 2'd1,
    RESTORE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(NUM_GROUPS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grp_q, grp_d;
  logic             done_q, done_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      grp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    grp_d            = grp_q;
    done_d           = 1'b0;
    rrat_rd_idx_o    = '0;
    rat_wr_en_o      = 1'b0;
    rat_wr_idx_o     = '0;
    rat_wr_data_o    = '0;
    fl_restore_en_o  = 1'b0;
    dispatch_stall_o = 1'b0;
    ct_hold_o        = 1'b0;
    recovery_busy_o  = 1'b0;
    // The completion pulse is a registered flag so it lands in the first
    // IDLE cycle after RESTORE, independent of a coincident new squash.
    recovery_done_o  = done_q;

    unique case (state_q)
      IDLE: begin
        if (squash_req_i) begin
          state_d = COPY;
          grp_d   = '0;
        end
      end

      COPY: begin
        rrat_rd_idx_o    = grp_q;
        rat_wr_en_o      = 1'b1;
        rat_wr_idx_o     = grp_q;
        rat_wr_data_o    = rrat_rd_data_i;
        dispatch_stall_o = 1'b1;
        ct_hold_o        = 1'b1;
        recovery_busy_o  = 1'b1;
        if (squash_req_i) begin
          // Restart: the partially rebuilt RAT is simply overwritten.
          grp_d = '0;
        end else if (grp_q == LAST_GRP) begin
          // Leave the counter on the last group instead of wrapping it.
          state_d = RESTORE;
        end else begin
          grp_d = grp_q + IDX_W'(1);
        end
      end

      RESTORE: begin
        fl_restore_en_o  = 1'b1;
        dispatch_stall_o = 1'b1;
        ct_hold_o        = 1'b1;
        recovery_busy_o  = 1'b1;
        if (squash_req_i) begin
          // Aborted pass: no completion pulse is owed.
          state_d = COPY;
          grp_d   = '0;
        end else begin
          state_d = IDLE;
          grp_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grp_d   = '0;
      end
    endcase
  end

`ifdef RAT_RECOVERY_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0] squash_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      squash_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (squash_req_i && (squash_cnt_q != 32'hFFFF_FFFF)) begin
        squash_cnt_q <= squash_cnt_q + 32'd1;
      end
      if (dispatch_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_squash_cnt_o   = squash_cnt_q;
  assign perf_stall_cycles_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rat_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_recovery_ctrl
// Purpose  : Self-checking bench for rat_recovery_ctrl. Expected outputs for
//            the next cycle are pushed to a queue when stimulus is driven and
//            popped and compared against the DUT one cycle later. Expected
//            values come from the squash-to-output timeline (cycle offsets
//            from the most recent accepted squash).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rat_recovery_ctrl;

  localparam int ARCH_REGS  = 32;
  localparam int PRN_WIDTH  = 6;
  localparam int COPY_WIDTH = 4;
  localparam int N          = ARCH_REGS / COPY_WIDTH;
  localparam int IDX_W      = $clog2(N);
  localparam int DATA_W     = COPY_WIDTH * PRN_WIDTH;

  logic              clock_i;
  logic              reset_i;
  logic              squash_req_i;
  logic [IDX_W-1:0]  rrat_rd_idx_o;
  logic [DATA_W-1:0] rrat_rd_data_i;
  logic              rat_wr_en_o;
  logic [IDX_W-1:0]  rat_wr_idx_o;
  logic [DATA_W-1:0] rat_wr_data_o;
  logic              fl_restore_en_o;
  logic              dispatch_stall_o;
  logic              ct_hold_o;
  logic              recovery_busy_o;
  logic              recovery_done_o;
`ifdef RAT_RECOVERY_PERF_EN
  logic [31:0]       perf_squash_cnt_o;
  logic [31:0]       perf_stall_cycles_o;
`endif

  rat_recovery_ctrl #(
    .ARCH_REGS  (ARCH_REGS),
    .PRN_WIDTH  (PRN_WIDTH),
    .COPY_WIDTH (COPY_WIDTH)
  ) u_dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .squash_req_i     (squash_req_i),
    .rrat_rd_idx_o    (rrat_rd_idx_o),
    .rrat_rd_data_i   (rrat_rd_data_i),
    .rat_wr_en_o      (rat_wr_en_o),
    .rat_wr_idx_o     (rat_wr_idx_o),
    .rat_wr_data_o    (rat_wr_data_o),
    .fl_restore_en_o  (fl_restore_en_o),
    .dispatch_stall_o (dispatch_stall_o),
    .ct_hold_o        (ct_hold_o),
    .recovery_busy_o  (recovery_busy_o),
    .recovery_done_o  (recovery_done_o)
`ifdef RAT_RECOVERY_PERF_EN
    ,
    .perf_squash_cnt_o   (perf_squash_cnt_o),
    .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // RRAT model: group k holds {4k+3, 4k+2, 4k+1, 4k}.
  function automatic logic [DATA_W-1:0] grp_data(input int g);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < COPY_WIDTH; i++) begin
      d[i*PRN_WIDTH +: PRN_WIDTH] = PRN_WIDTH'(COPY_WIDTH * g + i);
    end
    return d;
  endfunction

  always_comb begin
    rrat_rd_data_i = grp_data(int'(rrat_rd_idx_o));
  end

  typedef struct packed {
    logic              wr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              fl;
    logic              stall;
    logic              busy;
    logic              done;
    logic [31:0]       sq_cnt;
    logic [31:0]       st_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   sq_cyc = 0;
  bit   sq_v   = 1'b0;
  logic [31:0] m_sq_cnt = '0;
  logic [31:0] m_st_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  // Expected outputs in cycle c, from the offset to the latest accepted squash.
  function automatic exp_t model(input int c);
    exp_t e;
    int   d;
    e = '0;
    if (sq_v) begin
      d = c - sq_cyc;
      if (d >= 1 && d <= N) begin
        e.wr_en = 1'b1;
        e.idx   = IDX_W'(d - 1);
        e.data  = grp_data(d - 1);
        e.stall = 1'b1;
        e.busy  = 1'b1;
      end else if (d == N + 1) begin
        e.fl    = 1'b1;
        e.stall = 1'b1;
        e.busy  = 1'b1;
      end else if (d == N + 2) begin
        e.done  = 1'b1;
      end
    end
    return e;
  endfunction

  // One cycle: compare the DUT against the popped expectation, then drive
  // this cycle's inputs and push the expectation for the next cycle.
  task automatic step(input logic rst_in, input logic sq_in);
    exp_t e_nxt;
    @(negedge clock_i);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      e_cur = '0;
    end else begin
      e_cur = exp_q.pop_front();
      check("rat_wr_en",      {63'd0, rat_wr_en_o},      {63'd0, e_cur.wr_en});
      check("rat_wr_idx",     64'(rat_wr_idx_o),         64'(e_cur.idx));
      check("rrat_rd_idx",    64'(rrat_rd_idx_o),        64'(e_cur.idx));
      check("rat_wr_data",    64'(rat_wr_data_o),        64'(e_cur.data));
      check("fl_restore_en",  {63'd0, fl_restore_en_o},  {63'd0, e_cur.fl});
      check("dispatch_stall", {63'd0, dispatch_stall_o}, {63'd0, e_cur.stall});
      check("ct_hold",        {63'd0, ct_hold_o},        {63'd0, e_cur.stall});
      check("recovery_busy",  {63'd0, recovery_busy_o},  {63'd0, e_cur.busy});
      check("recovery_done",  {63'd0, recovery_done_o},  {63'd0, e_cur.done});
`ifdef RAT_RECOVERY_PERF_EN
      check("perf_squash_cnt",   64'(perf_squash_cnt_o),   64'(e_cur.sq_cnt));
      check("perf_stall_cycles", 64'(perf_stall_cycles_o), 64'(e_cur.st_cnt));
`endif
    end

    reset_i      = rst_in;
    squash_req_i = sq_in;

    if (!rst_in) begin
      sq_v     = 1'b0;
      m_sq_cnt = '0;
      m_st_cnt = '0;
    end else begin
      if (sq_in) begin
        sq_v   = 1'b1;
        sq_cyc = cyc;
        if (m_sq_cnt != 32'hFFFF_FFFF) m_sq_cnt++;
      end
      if (e_cur.stall && m_st_cnt != 32'hFFFF_FFFF) m_st_cnt++;
    end

    e_nxt        = model(cyc + 1);
    e_nxt.sq_cnt = m_sq_cnt;
    e_nxt.st_cnt = m_st_cnt;
    exp_q.push_back(e_nxt);
    cyc++;
  endtask

  initial begin
    // Reset held for 3 cycles with squash asserted; the squash must be ignored.
    reset_i      = 1'b0;
    squash_req_i = 1'b1;
    @(posedge clock_i);
    e_cur = '0;
    exp_q.push_back(e_cur);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);

    // Basic recovery.
    for (int k = 0; k < 14; k++) step(1'b1, k == 0);
    // Restart mid-COPY at cycle 5.
    for (int k = 0; k < 18; k++) step(1'b1, k == 0 || k == 5);
    // Squash during RESTORE at cycle 9.
    for (int k = 0; k < 22; k++) step(1'b1, k == 0 || k == 9);
    // Back-to-back: squash coincident with recovery_done.
    for (int k = 0; k < 24; k++) step(1'b1, k == 0 || k == 10);
    // Reset mid-walk at cycle 4.
    for (int k = 0; k < 10; k++) step(k != 4, k == 0);

    // Fresh run: two full recoveries for the perf counters.
    step(1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, k == 0);
    for (int k = 0; k < 12; k++) step(1'b1, k == 0);
    step(1'b1, 1'b0);
`ifdef RAT_RECOVERY_PERF_EN
    check("perf_squash_total", 64'(perf_squash_cnt_o),   64'd2);
    check("perf_stall_total",  64'(perf_stall_cycles_o), 64'd18);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
